// File: rtl/hamming_rx_deser_if.sv
// Serial-in / nibble-out bus of the Hamming(7,4) receive deserializer.
// master drives the serial line and consumer ready; slave is the deserializer.
interface hamming_rx_deser_if #(
    parameter int CNT_W = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             sof;
    logic             cnt_clr;
    logic [3:0]       data_out;
    logic             out_valid;
    logic             out_ready;
    logic             err_corrected;
    logic             overflow;
    logic [CNT_W-1:0] err_count;

    modport master (
        output ser_in, ser_valid, sof, cnt_clr, out_ready,
        input  data_out, out_valid, err_corrected, overflow, err_count
    );

    modport slave (
        input  ser_in, ser_valid, sof, cnt_clr, out_ready,
        output data_out, out_valid, err_corrected, overflow, err_count
    );
endinterface

// File: rtl/hamming_rx_deser.sv
// Bit-serial Hamming(7,4) receiver: frames on sof, corrects single-bit errors,
// holds the nibble in a valid/ready register and counts corrected words.
module hamming_rx_deser #(
    parameter int CNT_W     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    hamming_rx_deser_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] sreg, sreg_n;
    logic [6:0] cw_full, cw_fix;
    logic [2:0] syn;
    logic       word_done;
    logic       load;

    // Place serial bit k at its codeword position according to bit order.
    function automatic logic [6:0] put_bit(input logic [6:0] w, input logic [2:0] k,
                                           input logic b);
        logic [6:0] r;
        r = w;
        if (LSB_FIRST != 0) r[k] = b;
        else                r[3'd6 - k] = b;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            sreg    <= sreg_n;
        end
    end

    // sof restarts framing from any state, discarding a partial word.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sreg_n    = sreg;
        word_done = 1'b0;
        cw_full   = put_bit(sreg, bit_cnt, bus.ser_in);
        if (bus.ser_valid) begin
            if (bus.sof) begin
                state_n   = SHIFT;
                bit_cnt_n = 3'd1;
                sreg_n    = put_bit(7'd0, 3'd0, bus.ser_in);
            end else if (state == SHIFT) begin
                if (bit_cnt == 3'd6) begin
                    word_done = 1'b1;
                    state_n   = IDLE;
                    bit_cnt_n = 3'd0;
                    sreg_n    = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    sreg_n    = cw_full;
                end
            end
        end
    end

    always_comb begin
        syn[0] = cw_full[0] ^ cw_full[2] ^ cw_full[4] ^ cw_full[6];
        syn[1] = cw_full[1] ^ cw_full[2] ^ cw_full[5] ^ cw_full[6];
        syn[2] = cw_full[3] ^ cw_full[4] ^ cw_full[5] ^ cw_full[6];
        cw_fix = cw_full;
        if (syn != 3'd0) cw_fix[syn - 3'd1] = ~cw_full[syn - 3'd1];
    end

    // A completing word may replace a word being consumed on the same edge.
    assign load = word_done && (!bus.out_valid || bus.out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.data_out      <= '0;
            bus.err_corrected <= 1'b0;
            bus.overflow      <= 1'b0;
            bus.err_count     <= '0;
        end else begin
            bus.overflow <= word_done && !load;
            if (load) begin
                bus.out_valid     <= 1'b1;
                bus.data_out      <= {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
                bus.err_corrected <= (syn != 3'd0);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (bus.cnt_clr)
                bus.err_count <= '0;
            else if (load && syn != 3'd0 && bus.err_count != CNT_MAX)
                bus.err_count <= bus.err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hamming_rx_deser.sv
// Directed bench: two instances (8-bit and 2-bit error counters) share the
// same serial stimulus; expected nibbles are hand-computed Hamming(7,4) words.
module tb_hamming_rx_deser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser_in = 1'b0, ser_valid = 1'b0, sof = 1'b0, cnt_clr = 1'b0, out_ready = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hamming_rx_deser_if #(.CNT_W(8)) ifa ();
    hamming_rx_deser_if #(.CNT_W(2)) ifb ();

    assign ifa.ser_in = ser_in;  assign ifa.ser_valid = ser_valid;  assign ifa.sof = sof;
    assign ifa.cnt_clr = cnt_clr;  assign ifa.out_ready = out_ready;
    assign ifb.ser_in = ser_in;  assign ifb.ser_valid = ser_valid;  assign ifb.sof = sof;
    assign ifb.cnt_clr = cnt_clr;  assign ifb.out_ready = out_ready;

    hamming_rx_deser #(.CNT_W(8), .LSB_FIRST(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    hamming_rx_deser #(.CNT_W(2), .LSB_FIRST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bits are driven on the falling edge and accepted on the next rising edge.
    task automatic send_bits(input logic [6:0] cw, input int n, input logic with_sof);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ser_in    = cw[k];
            ser_valid = 1'b1;
            sof       = with_sof && (k == 0);
        end
    endtask

    task automatic idle_edge();
        @(negedge clk);
        ser_valid = 1'b0;
        sof       = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] cw, input logic clr_last, input logic rdy_last);
        send_bits(cw, 6, 1'b1);
        @(negedge clk);
        ser_in    = cw[6];
        ser_valid = 1'b1;
        sof       = 1'b0;
        if (clr_last) cnt_clr = 1'b1;
        if (rdy_last) out_ready = 1'b1;
        idle_edge();
    endtask

    initial begin
        logic [6:0] cw;
        repeat (2) @(negedge clk);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_data", ifa.data_out, 0);
        chk("rst_errc", ifa.err_corrected, 0);
        chk("rst_ovf", ifa.overflow, 0);
        chk("rst_cnt", ifa.err_count, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        send_frame(7'h52, 1'b0, 1'b0);
        chk("clean_A_data", ifa.data_out, 4'hA);
        chk("clean_A_valid", ifa.out_valid, 1);
        chk("clean_A_errc", ifa.err_corrected, 0);
        send_frame(7'h7F, 1'b0, 1'b0);
        chk("clean_F_data", ifa.data_out, 4'hF);
        chk("clean_F_errc", ifa.err_corrected, 0);
        send_frame(7'h00, 1'b0, 1'b0);
        chk("clean_0_data", ifa.data_out, 4'h0);
        chk("clean_0_valid", ifa.out_valid, 1);
        send_frame(7'h2D, 1'b0, 1'b0);
        chk("clean_5_data", ifa.data_out, 4'h5);
        chk("clean_cnt", ifa.err_count, 0);

        for (int i = 0; i < 7; i++) begin
            cw = 7'h52 ^ (7'd1 << i);
            send_frame(cw, 1'b0, 1'b0);
            chk($sformatf("inj%0d_data", i), ifa.data_out, 4'hA);
            chk($sformatf("inj%0d_errc", i), ifa.err_corrected, 1);
        end
        chk("inj_cnt8", ifa.err_count, 7);
        chk("inj_cnt2_sat", ifb.err_count, 3);

        send_frame(7'h42, 1'b1, 1'b0);
        chk("clr_errc", ifa.err_corrected, 1);
        chk("clr_cnt8", ifa.err_count, 0);
        chk("clr_cnt2", ifb.err_count, 0);
        idle_edge();
        chk("drain_valid", ifa.out_valid, 0);

        out_ready = 1'b0;
        send_frame(7'h52, 1'b0, 1'b0);
        chk("bp_hold_data", ifa.data_out, 4'hA);
        chk("bp_hold_ovf", ifa.overflow, 0);
        send_frame(7'h7F, 1'b0, 1'b0);
        chk("bp_ovf_pulse", ifa.overflow, 1);
        chk("bp_keep_data", ifa.data_out, 4'hA);
        chk("bp_keep_valid", ifa.out_valid, 1);
        idle_edge();
        chk("bp_ovf_end", ifa.overflow, 0);
        chk("bp_cnt", ifa.err_count, 0);
        send_frame(7'h2D, 1'b0, 1'b1);
        chk("bp_load_data", ifa.data_out, 4'h5);
        chk("bp_load_valid", ifa.out_valid, 1);
        chk("bp_load_ovf", ifa.overflow, 0);
        idle_edge();
        chk("bp_consumed", ifa.out_valid, 0);

        send_bits(7'h52, 4, 1'b1);
        idle_edge();
        chk("resync_partial", ifa.out_valid, 0);
        send_frame(7'h7F, 1'b0, 1'b0);
        chk("resync_data", ifa.data_out, 4'hF);
        chk("resync_valid", ifa.out_valid, 1);
        chk("resync_ovf", ifa.overflow, 0);
        idle_edge();
        chk("resync_one", ifa.out_valid, 0);

        out_ready = 1'b0;
        send_frame(7'h53, 1'b0, 1'b0);
        chk("pre_rst_errc", ifa.err_corrected, 1);
        chk("pre_rst_cnt", ifa.err_count, 1);
        send_bits(7'h52, 3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ifa.out_valid, 0);
        chk("mid_rst_data", ifa.data_out, 0);
        chk("mid_rst_errc", ifa.err_corrected, 0);
        chk("mid_rst_cnt", ifa.err_count, 0);
        idle_edge();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_bits(7'h7F, 3, 1'b0);
        idle_edge();
        repeat (3) idle_edge();
        chk("tail_no_out", ifa.out_valid, 0);
        chk("tail_no_ovf", ifa.overflow, 0);
        send_frame(7'h2D, 1'b0, 1'b0);
        chk("post_rst_data", ifa.data_out, 4'h5);
        chk("post_rst_valid", ifa.out_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
